wave_scheduler: RTL

Sequences enemy waves inside each playing level of the air-fighter game. Sits between the game state FSM and the enemy sprite spawner: it consumes the current level, issues spawn requests over a req/ack handshake, tracks kills and escapes, and returns the one-hot level-clear code that advances the game FSM to the next level.

---
 rtl/wave_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/wave_scheduler.sv
// Enemy wave sequencer: turns the current level into spawn requests and returns a one-hot level-clear code.
// Define WAVE_BOSS_EN to add a boss spawn at the end of the final wave of level 3.
module wave_scheduler #(
  parameter int WAVES_PER_LEVEL  = 4,
  parameter int SPAWN_GAP_FRAMES = 30,
  parameter int WAVE_GAP_FRAMES  = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       i_frame_tick,
  input  logic [2:0] i_level,
  input  logic       i_spawn_ack,
  input  logic       i_enemy_killed,
  input  logic       i_enemy_escaped,
  output logic       o_spawn_req,
  output logic [1:0] o_spawn_type,
  output logic [9:0] o_spawn_x,
  output logic [2:0] o_wave,
  output logic [2:0] o_level_clear
);

  // state   | meaning
  // S_IDLE  | not playing, all outputs low
  // S_GAP   | quiet period before a wave
  // S_SPAWN | spawn request raised, waiting for ack
  // S_SPACE | spacing between spawns of one wave
  // S_DRAIN | all spawns issued, waiting for every enemy to resolve
  // S_CLEAR | level finished, clear code held until the level changes
  typedef enum logic [2:0] {S_IDLE, S_GAP, S_SPAWN, S_SPACE, S_DRAIN, S_CLEAR} state_t;

  localparam logic [7:0] LP_SPAWN_GAP = 8'(SPAWN_GAP_FRAMES);
  localparam logic [7:0] LP_WAVE_GAP  = 8'(WAVE_GAP_FRAMES);
  localparam logic [2:0] LP_LAST_WAVE = 3'(WAVES_PER_LEVEL - 1);

  state_t      r_state;
  logic [2:0]  r_prev_level;
  logic [7:0]  r_timer;
  logic [3:0]  r_quota;
  logic [3:0]  r_spawned;
  logic [3:0]  r_resolved;
  logic [15:0] r_lfsr;

  logic        w_level_change;
  logic        w_level_valid;
  logic        w_lfsr_fb;
  logic        w_counting;
  logic [1:0]  w_resolve_inc;
  logic [4:0]  w_resolve_sum;
  logic [3:0]  w_resolved_next;
  logic [3:0]  w_quota_base;
  logic        w_boss;
  logic        w_boss_slot;
  logic [2:0]  w_clear_code;

  assign w_level_change = (i_level != r_prev_level);
  assign w_level_valid  = ~i_level[2] & (i_level[1:0] != 2'd0);
  assign w_lfsr_fb      = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_counting     = (r_state == S_SPAWN) || (r_state == S_SPACE) || (r_state == S_DRAIN);
  assign w_resolve_inc  = {1'b0, i_enemy_killed} + {1'b0, i_enemy_escaped};
  assign w_resolve_sum  = {1'b0, r_resolved} + {3'b000, w_resolve_inc};

  // Resolves never exceed the number of enemies actually on screen.
  always_comb begin
    w_resolved_next = r_resolved;
    if (w_counting) begin
      if (w_resolve_sum >= {1'b0, r_spawned})
        w_resolved_next = r_spawned;
      else
        w_resolved_next = w_resolve_sum[3:0];
    end
  end

  assign w_quota_base = {1'b0, r_prev_level[1:0], 1'b0} + 4'd2;

`ifdef WAVE_BOSS_EN
  assign w_boss = (r_prev_level == 3'd3) && (o_wave == LP_LAST_WAVE);
`else
  assign w_boss = 1'b0;
`endif
  assign w_boss_slot = w_boss && (r_spawned == w_quota_base);

  always_comb begin
    case (r_prev_level)
      3'd1:    w_clear_code = 3'b001;
      3'd2:    w_clear_code = 3'b010;
      3'd3:    w_clear_code = 3'b100;
      default: w_clear_code = 3'b000;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_prev_level  <= 3'd0;
      r_timer       <= 8'd0;
      r_quota       <= 4'd0;
      r_spawned     <= 4'd0;
      r_resolved    <= 4'd0;
      r_lfsr        <= 16'hACE1;
      o_spawn_req   <= 1'b0;
      o_spawn_type  <= 2'd0;
      o_spawn_x     <= 10'd0;
      o_wave        <= 3'd0;
      o_level_clear <= 3'd0;
    end else begin
      r_lfsr       <= {w_lfsr_fb, r_lfsr[15:1]};
      r_prev_level <= i_level;
      r_resolved   <= w_resolved_next;
      if (w_level_change) begin
        o_spawn_req   <= 1'b0;
        o_level_clear <= 3'd0;
        o_wave        <= 3'd0;
        r_spawned     <= 4'd0;
        r_resolved    <= 4'd0;
        r_timer       <= LP_WAVE_GAP;
        if (w_level_valid) begin
          r_state <= S_GAP;
        end else begin
          r_state      <= S_IDLE;
          o_spawn_type <= 2'd0;
          o_spawn_x    <= 10'd0;
        end
      end else begin
        case (r_state)
          S_IDLE: ;
          S_GAP: begin
            if (r_timer == 8'd0) begin
              r_state      <= S_SPAWN;
              r_quota      <= w_quota_base + {3'b000, w_boss};
              r_spawned    <= 4'd0;
              o_spawn_req  <= 1'b1;
              o_spawn_type <= r_prev_level[1:0] - 2'd1;
              o_spawn_x    <= {1'b0, r_lfsr[8:0]} + 10'd32;
            end else if (i_frame_tick) begin
              r_timer <= r_timer - 8'd1;
            end
          end
          S_SPAWN: begin
            if (o_spawn_req && i_spawn_ack) begin
              o_spawn_req <= 1'b0;
              r_spawned   <= r_spawned + 4'd1;
              if ((r_spawned + 4'd1) == r_quota) begin
                r_state <= S_DRAIN;
              end else begin
                r_state <= S_SPACE;
                r_timer <= LP_SPAWN_GAP;
              end
            end
          end
          S_SPACE: begin
            if (r_timer == 8'd0) begin
              r_state      <= S_SPAWN;
              o_spawn_req  <= 1'b1;
              o_spawn_type <= w_boss_slot ? 2'b11 : (r_prev_level[1:0] - 2'd1);
              o_spawn_x    <= w_boss_slot ? 10'd288 : ({1'b0, r_lfsr[8:0]} + 10'd32);
            end else if (i_frame_tick) begin
              r_timer <= r_timer - 8'd1;
            end
          end
          S_DRAIN: begin
            if (w_resolved_next == r_spawned) begin
              if (o_wave < LP_LAST_WAVE) begin
                o_wave     <= o_wave + 3'd1;
                r_state    <= S_GAP;
                r_timer    <= LP_WAVE_GAP;
                r_spawned  <= 4'd0;
                r_resolved <= 4'd0;
              end else begin
                r_state       <= S_CLEAR;
                o_level_clear <= w_clear_code;
              end
            end
          end
          S_CLEAR: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
